// File: rtl/gpr_arb_pkg.sv
// Shared types and default sizing for the GPR arbiter.
package gpr_arb_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefSelWidth  = 3;
  localparam int unsigned DefTimeout   = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Counter must be able to hold the value Timeout itself.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick with a last-grant pointer.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,     // {b, a}
  input  logic       update_i,  // record win_i as the last grant
  input  logic [1:0] win_i,     // one-hot winner of the finishing transaction
  output logic [1:0] gnt_o      // one-hot {b, a}
);

  // High when B was granted last, so A wins the next tie.
  logic last_b_q, last_b_d;

  // Grant decode and pointer next state.
  always_comb begin
    gnt_o    = 2'b00;
    last_b_d = last_b_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_b_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (update_i) begin
      last_b_d = win_i[1];
    end
  end

  // Pointer register; reset leaves A with priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_b_q <= 1'b1;
    end else begin
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: rtl/gpr_arbiter.sv
// Two-port arbiter/sequencer onto the GPR file cs/write/address/data/rdy bus.
module gpr_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int unsigned DataWidth = DefDataWidth,
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned SelWidth  = DefSelWidth,
  parameter int unsigned Timeout   = DefTimeout
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 a_req_i,
  input  logic                 a_write_i,
  input  logic [SelWidth-1:0]  a_addr_i,
  input  logic [DataWidth-1:0] a_wdata_i,
  output logic                 a_gnt_o,
  output logic                 a_done_o,
  output logic [DataWidth-1:0] a_rdata_o,
  input  logic                 b_req_i,
  input  logic                 b_write_i,
  input  logic [SelWidth-1:0]  b_addr_i,
  input  logic [DataWidth-1:0] b_wdata_i,
  output logic                 b_gnt_o,
  output logic                 b_done_o,
  output logic [DataWidth-1:0] b_rdata_o,
  output logic                 err_o,
  output logic                 gpr_cs_o,
  output logic                 gpr_write_o,
  output logic [AddrWidth-1:0] gpr_address_o,
  inout  wire  [DataWidth-1:0] gpr_data_io,
  input  logic                 gpr_rdy_i
);

  localparam int unsigned CntW = cnt_width(Timeout);

  state_e               state_q, state_d;
  logic [1:0]           win_q, win_d;      // one-hot {b, a}
  logic                 write_q, write_d;
  logic [SelWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 seen_low_q, seen_low_d;
  logic                 abort_q, abort_d;
  logic [DataWidth-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [1:0]           arb_gnt;
  logic                 arb_update;
  logic                 bus_busy;

  rr_arbiter2 u_rr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({b_req_i, a_req_i}),
    .update_i (arb_update),
    .win_i    (win_q),
    .gnt_o    (arb_gnt)
  );

  // Sequencer next state: arbitrate, issue, wait for rdy low->high or timeout, finish.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    abort_d    = abort_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    arb_update = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gpr_rdy_i && (a_req_i || b_req_i)) begin
          win_d   = arb_gnt;
          write_d = arb_gnt[1] ? b_write_i : a_write_i;
          addr_d  = arb_gnt[1] ? b_addr_i  : a_addr_i;
          wdata_d = arb_gnt[1] ? b_wdata_i : a_wdata_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d      = '0;
        seen_low_d = 1'b0;
        abort_d    = 1'b0;
        state_d    = StWait;
      end
      StWait: begin
        if (!gpr_rdy_i) begin
          seen_low_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        // A completing handshake wins over a coincident timeout.
        if (gpr_rdy_i && seen_low_q) begin
          if (!write_q) begin
            if (win_q[1]) begin
              b_rdata_d = gpr_data_io;
            end else begin
              a_rdata_d = gpr_data_io;
            end
          end
          state_d = StDone;
        end else if (cnt_d == CntW'(Timeout)) begin
          abort_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        arb_update = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, transaction latch, timeout counter and read-data registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      win_q      <= 2'b00;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      abort_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      abort_q    <= abort_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Outputs decoded from registered state only.
  assign bus_busy      = (state_q == StIssue) || (state_q == StWait);
  assign a_gnt_o       = (state_q == StIssue) && win_q[0];
  assign b_gnt_o       = (state_q == StIssue) && win_q[1];
  assign a_done_o      = (state_q == StDone) && win_q[0];
  assign b_done_o      = (state_q == StDone) && win_q[1];
  assign err_o         = (state_q == StDone) && abort_q;
  assign a_rdata_o     = a_rdata_q;
  assign b_rdata_o     = b_rdata_q;
  assign gpr_cs_o      = bus_busy;
  assign gpr_write_o   = bus_busy && write_q;
  assign gpr_address_o = {{(AddrWidth - SelWidth){1'b0}}, addr_q};

  // The register file owns the bus during reads and whenever we are idle.
  assign gpr_data_io = (bus_busy && write_q) ? wdata_q : {DataWidth{1'bz}};

endmodule

// File: doc/gpr_arbiter.md
# gpr_arbiter

Two-port round-robin arbiter and sequencer for the 8-entry general-purpose register file. It accepts single-word read/write requests from two requesters (A: fetch/decode, B: execute/writeback) and serialises them onto the register file's cs/write/address/shared-data/rdy interface. It holds the shared bus for the whole transaction and returns read data. It flags register-file timeouts and recovers from them.

## Interface
- DATA_WIDTH, 16, register and bus data width
- ADDR_WIDTH, 16, register-file address bus width
- SEL_WIDTH, 3, register index width; upper address bits are driven 0
- TIMEOUT, 15, maximum cycles allowed in WAIT before abort

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  reset; synchronous and active-high, sampled on rising clk
- a_req / b_req  in  1  request; held high until the matching done
- a_write / b_write  in  1  1 = write, 0 = read
- a_addr / b_addr  in  SEL_WIDTH  register index
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_gnt / b_gnt  out  1  one-cycle pulse when the request is accepted
- a_done / b_done  out  1  one-cycle pulse on completion
- a_rdata / b_rdata  out  DATA_WIDTH  read data, valid with done, held until next done to that port
- err  out  1  one-cycle pulse coincident with done when the transaction timed out
- gpr_cs  out  1  register-file select
- gpr_write  out  1  register-file write strobe
- gpr_address  out  ADDR_WIDTH  register-file address
- gpr_data  inout  DATA_WIDTH  shared data bus
- gpr_rdy  in  1  register-file ready

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If gpr_rdy=1 and any req is high, arbitrate.
  - Latch the winner's write/addr/wdata and go to ISSUE.
  - If gpr_rdy=0, stay in IDLE.
- **Arbitration**
  - Round-robin with a last-grant pointer; after reset A has priority.
  - A lone requester always wins.
  - On simultaneous requests, the port not granted last wins.
  - The pointer updates in DONE.
- **ISSUE** (1 cycle)
  - gpr_cs=1; gnt pulse to the winner; clear the timeout counter and the seen_low flag.
  - Go to WAIT.
- **WAIT**
  - gpr_cs stays 1; address/write/wdata held stable.
  - Set seen_low when gpr_rdy=0.
  - Completion: gpr_rdy=1 with seen_low set.
    - On a read, capture gpr_data into the winner's rdata.
    - Go to DONE.
  - The counter increments each WAIT cycle. If it reaches TIMEOUT, go to DONE with the abort flag set; rdata is left unchanged.
- **DONE** (1 cycle)
  - gpr_cs=0; done pulse to the winner; err=abort flag.
  - Update the pointer; go to IDLE.
- **Bus drive**
  - The controller drives gpr_data with the latched wdata only in ISSUE/WAIT with gpr_write=1.
  - Otherwise gpr_data is high-Z; during reads the register file owns the bus.
- **Request handling**
  - A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
  - A req held after done is treated as a new request.
- **Reset**
  - Applies in any state, including mid-WAIT: state=IDLE, pointer→A, counter=0.
  - All outputs 0; rdata=0; gpr_data high-Z.
  - The aborted transaction produces no done.

## Timing
- All outputs are registered or decoded from the registered state; there is no combinational req→gnt path.
- Request sampled at edge n (IDLE) → ISSUE in cycle n+1 (gnt=1, gpr_cs=1).
- WAIT starts at n+2; done is no earlier than cycle n+4.
- Against a register file that drops rdy for 2 cycles: done at n+5 (5-cycle latency).
- Back-to-back throughput: one transaction per 6 cycles (DONE→IDLE→ISSUE).
- Timeout: done+err at cycle n+2+TIMEOUT when gpr_rdy never falls, or stays low.
- gpr_address, gpr_write and driven gpr_data are stable from ISSUE through the last WAIT cycle.

## Structure
- Package gpr_arb_pkg holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3)
  - default width constants
  - timeout counter width = clog2(TIMEOUT+1)
- Sub-module rr_arbiter2 contains the two-request round-robin pick and pointer register (inputs: req[1:0], update; output: grant one-hot).
- The top level holds the FSM, the transaction latch, the timeout counter and the tri-state driver.

## Test plan
- A writes reg 3 = 0xA5A5:
  - a_gnt pulses once; gpr_address=0x0003 and gpr_data=0xA5A5 held through WAIT.
  - a_done at n+5; err=0.
- A reads reg 3 after the write → a_rdata=0xA5A5 with a_done; gpr_data is never driven by the controller during the read.
- a_req and b_req high together from reset, both held for 4 transactions:
  - grants go A,B,A,B.
  - b_rdata/a_rdata are unaffected by the other port's traffic.
- Register-file model holds gpr_rdy low forever, B reads reg 5:
  - b_done and err pulse at n+2+15.
  - b_rdata is unchanged; FSM returns to IDLE and serves the next request.
- rst asserted in the second WAIT cycle of an A write:
  - next cycle gpr_cs=0, gpr_data high-Z, no a_done.
  - after rst, A has priority on a simultaneous request.
- a_req dropped the cycle after a_gnt → transaction completes, a_done pulses once, no second grant.
